// File: rtl/input_cond_pkg.sv
// Shared types and sizing helpers for the input conditioner.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package input_cond_pkg;

    typedef enum logic [1:0] {
        REL   = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_t;

    // Bits needed to hold 0..limit-1, never less than one bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One conditioned input: synchroniser, polarity, debounce and auto-repeat FSM.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a clean raw change to level/pulse.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
module input_cond_ch
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic INVERT          = 1'b1,
    parameter int   REPEAT_DELAY    = 25000000,
    parameter int   REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic is_repeat
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = max_int(cnt_width(REPEAT_DELAY), cnt_width(REPEAT_PERIOD));

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          rc_q, rc_d;
    rpt_state_t             state_q, state_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   isr_q, isr_d;

    logic s;
    logic toggle;
    logic rise;
    logic fall;

    // Shift the raw pin into the synchroniser chain and undo the pin polarity.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
        s      = sync_q[SYNC_STAGES-1] ^ INVERT;
    end

    // Debounce: accept a change only after it has been stable for DEBOUNCE_CYCLES edges.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        toggle  = 1'b0;
        if (s != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = ~level_q;
                toggle  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise = toggle & ~level_q;
        fall = toggle & level_q;
    end

    // Edge pulses and auto-repeat; a release edge always wins over a due repeat.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        isr_d   = 1'b0;
        if (fall) begin
            state_d = REL;
            rc_d    = '0;
            rel_d   = 1'b1;
        end else if (rise) begin
            state_d = DELAY;
            rc_d    = '0;
            press_d = 1'b1;
        end else begin
            case (state_q)
                DELAY, RPT: begin
                    if (!repeat_en) begin
                        // Disabling restarts the full initial delay.
                        state_d = DELAY;
                        rc_d    = '0;
                    end else if (rc_q == ((state_q == DELAY) ? RD_LAST : RP_LAST)) begin
                        state_d = RPT;
                        rc_d    = '0;
                        press_d = 1'b1;
                        isr_d   = 1'b1;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = REL;
                    rc_d    = '0;
                end
            endcase
        end
    end

    // All channel state, including the repeat FSM, registered in one place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{INVERT}};
            cnt_q   <= '0;
            rc_q    <= '0;
            state_q <= REL;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            isr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            state_q <= state_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            isr_q   <= isr_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign is_repeat     = isr_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button/switch front end: clean level plus press/release/repeat pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a clean raw change to outputs.
// Backpressure: none; consumers must take pulses in the cycle they appear.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int              NUM_CH          = 4,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter logic [NUM_CH-1:0] INVERT_MASK   = {NUM_CH{1'b1}},
    parameter int              REPEAT_DELAY    = 25000000,
    parameter int              REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press,
    // "release" is a reserved word, hence the suffix.
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] is_repeat
);

    // Channels share nothing; each gets its own conditioner.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        input_cond_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (INVERT_MASK[i]),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .raw_in       (raw_in[i]),
            .repeat_en    (repeat_en[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .is_repeat    (is_repeat[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a timestamp-based model.
module tb_input_conditioner;

    localparam int S  = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [3:0] MASK = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] raw_in = 4'hF;
    logic [3:0] repeat_en = 4'h0;
    logic [3:0] level, press, release_pulse, is_repeat;

    input_conditioner #(
        .NUM_CH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DB),
        .INVERT_MASK(MASK), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .raw_in(raw_in), .repeat_en(repeat_en),
        .level(level), .press(press), .release_pulse(release_pulse),
        .is_repeat(is_repeat)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: raw samples delayed S edges, a stability run length,
    // and an absolute edge number at which the next repeat is due.
    bit         dq [4][$];
    int         run [4];
    int         due [4];
    int         ecount = 0;
    logic [3:0] m_lvl, m_press, m_rel, m_isr;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            dq[c].delete();
            for (int k = 0; k < S; k++) dq[c].push_back(MASK[c]);
            run[c] = 0;
            due[c] = 0;
        end
        m_lvl = '0; m_press = '0; m_rel = '0; m_isr = '0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] e);
        bit s, tog;
        ecount++;
        m_press = '0; m_rel = '0; m_isr = '0;
        for (int c = 0; c < 4; c++) begin
            s = dq[c].pop_front() ^ MASK[c];
            dq[c].push_back(r[c]);
            tog = 1'b0;
            if (s != m_lvl[c]) begin
                run[c]++;
                if (run[c] == DB) begin
                    run[c]   = 0;
                    tog      = 1'b1;
                    m_lvl[c] = s;
                    if (s) begin
                        m_press[c] = 1'b1;
                        due[c]     = ecount + RD;
                    end else begin
                        m_rel[c] = 1'b1;
                    end
                end
            end else begin
                run[c] = 0;
            end
            if (!tog && m_lvl[c]) begin
                if (!e[c]) begin
                    due[c] = ecount + RD;
                end else if (ecount == due[c]) begin
                    m_press[c] = 1'b1;
                    m_isr[c]   = 1'b1;
                    due[c]     = ecount + RP;
                end
            end
        end
    endtask

    // One clock: drive inputs just after an edge, check outputs just after the next.
    task automatic step(input logic [3:0] r, input logic [3:0] e);
        raw_in    = r;
        repeat_en = e;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(r, e);
        #1;
        chk("level", level, m_lvl);
        chk("press", press, m_press);
        chk("release", release_pulse, m_rel);
        chk("is_repeat", is_repeat, m_isr);
        chk("press_and_release", press & release_pulse, 4'h0);
    endtask

    task automatic async_reset_check(input string tag);
        #4;
        raw_in = 4'hF;
        rst    = 1'b1;
        #1;
        chk({tag, "_level"}, level, 4'h0);
        chk({tag, "_press"}, press, 4'h0);
        chk({tag, "_release"}, release_pulse, 4'h0);
        chk({tag, "_is_repeat"}, is_repeat, 4'h0);
        model_reset();
        @(posedge clk);
        #1;
        step(4'hF, 4'h0);
        step(4'hF, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(4'hF, 4'h0);
        chk({tag, "_after_level"}, level, 4'h0);
    endtask

    initial begin
        logic [3:0] r, e;
        int         pcnt;

        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst_level", level, 4'h0);
        chk("rst_press", press, 4'h0);
        chk("rst_release", release_pulse, 4'h0);
        chk("rst_is_repeat", is_repeat, 4'h0);
        @(posedge clk); #1;
        step(4'hF, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(4'hF, 4'h0);

        // Clean press and release on ch0.
        for (int i = 1; i <= 8; i++) begin
            step(4'hE, 4'h0);
            if (i == 5) chk("p0_early", level, 4'h0);
            if (i == 6) begin
                chk("p0_press", press, 4'h1);
                chk("p0_isr", is_repeat, 4'h0);
                chk("p0_level", level, 4'h1);
            end
            if (i == 7) chk("p0_press_gone", press, 4'h0);
        end
        for (int i = 1; i <= 8; i++) begin
            step(4'hF, 4'h0);
            if (i == 6) chk("r0_release", release_pulse, 4'h1);
            if (i == 7) chk("r0_release_gone", release_pulse, 4'h0);
        end

        // Bounce on ch1: short low burst is ignored, exactly one press afterwards.
        pcnt = 0;
        for (int i = 1; i <= 14; i++) begin
            step((i <= 3 || i >= 5) ? 4'hD : 4'hF, 4'h0);
            if (press[1]) pcnt++;
            if (i == 6) chk("bounce_no_early", level, 4'h0);
        end
        chk("bounce_cnt", 4'(pcnt), 4'h1);
        for (int i = 0; i < 8; i++) step(4'hF, 4'h0);

        // Auto-repeat on ch2, then release landing on a repeat-due edge.
        for (int i = 1; i <= 22; i++) begin
            step(4'hB, 4'h4);
            chk("rpt_press", press & 4'h4,
                (i == 6 || i == 16 || i == 19 || i == 22) ? 4'h4 : 4'h0);
            chk("rpt_isr", is_repeat & 4'h4,
                (i == 16 || i == 19 || i == 22) ? 4'h4 : 4'h0);
        end
        for (int i = 1; i <= 8; i++) begin
            step(4'hF, 4'h4);
            if (i == 6) begin
                chk("due_rel_release", release_pulse, 4'h4);
                chk("due_rel_press", press, 4'h0);
            end
        end

        // Dropping repeat_en for one edge restarts the full delay.
        for (int i = 1; i <= 30; i++) begin
            step(4'hB, (i == 17) ? 4'h0 : 4'h4);
            if (i == 16) chk("dis_first", is_repeat, 4'h4);
            if (i >= 18 && i <= 26) chk("dis_quiet", press & 4'h4, 4'h0);
            if (i == 27) begin
                chk("dis_resume", press, 4'h4);
                chk("dis_resume_isr", is_repeat, 4'h4);
            end
        end
        for (int i = 0; i < 8; i++) step(4'hF, 4'h0);

        // Independence: ch0 and ch3 pressed together, only ch3 repeats.
        for (int i = 1; i <= 20; i++) begin
            step(4'h6, 4'h8);
            if (i == 6) begin
                chk("ind_press", press, 4'h9);
                chk("ind_isr", is_repeat, 4'h0);
            end
            if (i == 16) begin
                chk("ind_rpt", press, 4'h8);
                chk("ind_rpt_isr", is_repeat, 4'h8);
            end
        end

        // Mid-cycle asynchronous reset while levels are active.
        async_reset_check("mid_rst");

        // Random phase: alternating fast-bounce and long-hold regimes.
        r = 4'hF;
        e = 4'h0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ((i / 100) % 2 == 0) begin
                    if ($urandom_range(3) == 0) r[c] = ~r[c];
                end else begin
                    if ($urandom_range(29) == 0) r[c] = ~r[c];
                end
            end
            if ($urandom_range(15) == 0) e = 4'($urandom);
            step(r, e);
            if (i == 300) begin
                async_reset_check("rand_rst");
                r = 4'hF;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
